// File: rtl/mem_copier_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_copier_if
// Description : picorv32-style native memory bus (initiator <-> responder).
//               The initiator raises mem_valid with address/strobe/data and
//               holds them until the responder answers with mem_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_copier_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // Bus initiator view (the copier)
    modport master (
        output mem_valid,
        output mem_instr,
        output mem_wstrb,
        output mem_wdata,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    // Bus responder view (memory)
    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_wstrb,
        input  mem_wdata,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_copier.sv
`default_nettype none
// ============================================================================
// Module      : mem_copier
// Description : Word-granular memory-to-memory copy engine acting as a
//               picorv32 native bus initiator.  Each word is moved with one
//               read and one write transaction, each followed by a bus idle
//               cycle.  A per-transaction wait counter aborts a stalled
//               transaction after TIMEOUT cycles and raises a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copier #(
    parameter int unsigned TIMEOUT = 255   // legal range 1..65535
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        start,
    input  wire logic [31:0] src_addr,
    input  wire logic [31:0] dst_addr,
    input  wire logic [15:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    mem_copier_if.master     bus
);

    // Last wait-counter value before the transaction is abandoned: mem_valid
    // is high for exactly TIMEOUT cycles when the responder never answers.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RGAP = 3'd2,
        WR   = 3'd3,
        WGAP = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs (current / next)
    // ------------------------------------------------------------------------
    state_t      state_q,  state_d;
    logic [29:0] src_q,    src_d;      // source word address
    logic [29:0] dst_q,    dst_d;      // destination word address
    logic [15:0] count_q,  count_d;    // words still to be written
    logic [31:0] data_q,   data_d;     // word captured by the last read
    logic [15:0] wait_q,   wait_d;     // cycles spent waiting for mem_ready
    logic        valid_q,  valid_d;
    logic [3:0]  wstrb_q,  wstrb_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] addr_q,   addr_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;
    logic        error_q,  error_d;

    // Responder inputs only matter while a request is actually outstanding.
    logic handshake;
    logic timed_out;

    // Byte-offset bits of the command addresses are dropped: transfers are
    // always word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

    assign handshake = valid_q & bus.mem_ready;
    assign timed_out = valid_q & ~bus.mem_ready & (wait_q == WAIT_LAST);

    // Next-state and next-output logic for the copy sequencer
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        count_d = count_q;
        data_d  = data_q;
        wait_d  = wait_q;
        valid_d = valid_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr[31:2];
                    dst_d   = dst_addr[31:2];
                    count_d = word_count;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    if (word_count == 16'd0) begin
                        // Nothing to move: finish through the write gap.
                        state_d = WGAP;
                    end else begin
                        state_d = RD;
                        valid_d = 1'b1;
                        wstrb_d = 4'b0000;
                        addr_d  = {src_addr[31:2], 2'b00};
                        wait_d  = 16'd0;
                    end
                end
            end

            RD: begin
                if (handshake) begin
                    data_d  = bus.mem_rdata;
                    valid_d = 1'b0;
                    state_d = RGAP;
                end else if (timed_out) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            RGAP: begin
                src_d   = src_q + 30'd1;
                state_d = WR;
                valid_d = 1'b1;
                wstrb_d = 4'b1111;
                wdata_d = data_q;
                addr_d  = {dst_q, 2'b00};
                wait_d  = 16'd0;
            end

            WR: begin
                if (handshake) begin
                    count_d = count_q - 16'd1;
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                    state_d = WGAP;
                end else if (timed_out) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            WGAP: begin
                dst_d = dst_q + 30'd1;
                if (count_q == 16'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD;
                    valid_d = 1'b1;
                    wstrb_d = 4'b0000;
                    addr_d  = {src_q, 2'b00};
                    wait_d  = 16'd0;
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                wstrb_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset abandons any transaction from the reset edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            src_q   <= 30'd0;
            dst_q   <= 30'd0;
            count_q <= 16'd0;
            data_q  <= 32'd0;
            wait_q  <= 16'd0;
            valid_q <= 1'b0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'd0;
            addr_q  <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            count_q <= count_d;
            data_q  <= data_d;
            wait_q  <= wait_d;
            valid_q <= valid_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // All outputs come straight from registers; the copier never fetches code.
    assign bus.mem_valid = valid_q;
    assign bus.mem_instr = 1'b0;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_addr  = addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_copier.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copier
// Description : Self-checking bench for mem_copier: table of copy commands
//               plus hand-written timeout, reset-mid-write and back-to-back
//               sequences.  Expected bus transactions are queued when a copy
//               is launched and compared as the responder observes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copier;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] n;
        int          lat;      // responder wait cycles per transaction
        logic [31:0] seed;     // first source word; later words add 0x11111111
        int          exp_cyc;  // first RD cycle to done cycle (0: not checked)
        int          poke;     // loop cycle at which a stray start is pulsed
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;
    logic        error;

    mem_copier_if bus ();

    mem_copier #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: sources written by the stimulus, destinations by the responder.
    logic [31:0] src_mem [logic [29:0]];
    logic [31:0] dst_mem [logic [29:0]];

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   obs_idx = 0;

    int checks = 0;
    int failures = 0;

    // Responder controls (written by the stimulus process only)
    int lat = 0;
    bit never_ready = 0;
    bit stall_writes = 0;

    // Responder-side invariant violation counters
    int stable_bad = 0;
    int instr_bad = 0;
    int wstrb_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder: decides mem_ready for the next edge while outputs are stable.
    initial begin : responder
        logic [31:0] p_addr, p_wdata;
        logic [3:0]  p_wstrb;
        bit          holding;
        int          wcnt;
        holding = 0;
        wcnt = 0;
        p_addr = 0; p_wdata = 0; p_wstrb = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_valid) begin
                if (holding && (bus.mem_addr !== p_addr || bus.mem_wstrb !== p_wstrb ||
                                bus.mem_wdata !== p_wdata))
                    stable_bad++;
                p_addr  = bus.mem_addr;
                p_wstrb = bus.mem_wstrb;
                p_wdata = bus.mem_wdata;
                if (!never_ready && !(stall_writes && bus.mem_wstrb != 4'h0) && wcnt >= lat) begin
                    bus.mem_ready = 1'b1;
                    obs_q.push_back('{bus.mem_addr, bus.mem_wstrb, bus.mem_wdata});
                    if (bus.mem_wstrb != 4'h0)
                        dst_mem[bus.mem_addr[31:2]] = bus.mem_wdata;
                    else if (src_mem.exists(bus.mem_addr[31:2]))
                        bus.mem_rdata = src_mem[bus.mem_addr[31:2]];
                    else
                        bus.mem_rdata = 32'hBAD0BAD0;
                    holding = 0;
                    wcnt = 0;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    holding = 1;
                    wcnt++;
                end
            end else begin
                // Random ready/data while idle must be ignored by the copier.
                bus.mem_ready = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
                holding = 0;
                wcnt = 0;
            end
            if (bus.mem_instr !== 1'b0) instr_bad++;
            if (!bus.mem_valid && bus.mem_wstrb !== 4'h0) wstrb_bad++;
        end
    end

    // Compare every newly observed transaction against the expected queue.
    task automatic drain();
        while (obs_idx < obs_q.size()) begin
            if (obs_idx < exp_q.size()) begin
                chk("txn_addr", obs_q[obs_idx].addr, exp_q[obs_idx].addr);
                chk("txn_wstrb", obs_q[obs_idx].wstrb, exp_q[obs_idx].wstrb);
                if (exp_q[obs_idx].wstrb == 4'hF)
                    chk("txn_wdata", obs_q[obs_idx].wdata, exp_q[obs_idx].wdata);
            end else begin
                chk("unexpected_txn", obs_q[obs_idx].addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end
            obs_idx++;
        end
    endtask

    function automatic logic [31:0] word_val(input vec_t v, input int i);
        return v.seed + 32'(i) * 32'h11111111;
    endfunction

    // Preload source words and queue the expected read/write sequence.
    task automatic prep(input vec_t v);
        for (int i = 0; i < int'(v.n); i++) begin
            src_mem[v.src[31:2] + 30'(i)] = word_val(v, i);
            exp_q.push_back('{{v.src[31:2] + 30'(i), 2'b00}, 4'h0, 32'h0});
            exp_q.push_back('{{v.dst[31:2] + 30'(i), 2'b00}, 4'hF, word_val(v, i)});
        end
    endtask

    task automatic check_dst(input vec_t v);
        for (int i = 0; i < int'(v.n); i++) begin
            logic [29:0] w;
            w = v.dst[31:2] + 30'(i);
            if (dst_mem.exists(w)) chk("dst_word", dst_mem[w], word_val(v, i));
            else                   chk("dst_word_missing", 0, 1);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        src_addr   = v.src;
        dst_addr   = v.dst;
        word_count = v.n;
        start      = 1'b1;
    endtask

    // Launch one copy at the current negedge and follow it to completion.
    task automatic run_copy(input vec_t v);
        int  vcyc, dones, first, dat;
        bit  fin;
        vcyc = 0; dones = 0; first = -1; dat = -1; fin = 0;
        lat = v.lat;
        prep(v);
        drive_cmd(v);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("error_after_start", error, 0);
        for (int c = 0; c < 2000 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            if (v.poke > 0 && c == v.poke) begin
                chk("busy_at_poke", busy, 1);
                src_addr   = 32'hDEAD0000;
                dst_addr   = 32'hBEEF0000;
                word_count = 16'd7;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (bus.mem_valid) begin
                vcyc++;
                if (first < 0) first = cyc;
            end
            if (done) begin
                dones++;
                dat = cyc;
                fin = 1;
            end
            drain();
        end
        start = 1'b0;
        if (!fin) chk("copy_finished", 0, 1);
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            drain();
        end
        chk("done_pulses", dones, 1);
        chk("error_end", error, 0);
        chk("busy_end", busy, 0);
        if (v.exp_cyc > 0) chk("copy_cycles", dat - first, v.exp_cyc);
        if (v.n == 16'd0) chk("zero_len_valid_cycles", vcyc, 0);
        check_dst(v);
        chk("all_txns_seen", obs_idx, exp_q.size());
    endtask

    vec_t vecs[5];

    initial begin : stimulus
        int   vcyc, dones;
        vec_t va, vb;
        bit   got;

        resetn = 1'b0;
        start = 1'b0;
        src_addr = 32'h0;
        dst_addr = 32'h0;
        word_count = 16'h0;

        //            src            dst           n      lat seed           cyc poke
        vecs[0] = '{32'h00000100, 32'h00000200, 16'd3, 0, 32'h11111111, 12, 0};
        vecs[1] = '{32'h00001000, 32'h00002000, 16'd2, 5, 32'hA5A50001, 28, 0};
        vecs[2] = '{32'h00000400, 32'h00000500, 16'd0, 0, 32'h00000000, 0,  0};
        vecs[3] = '{32'hFFFFFFFC, 32'h00000300, 16'd2, 0, 32'h5EED0000, 8,  0};
        vecs[4] = '{32'h00003000, 32'h00004000, 16'd4, 1, 32'h01020304, 24, 5};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_valid", bus.mem_valid, 0);
        chk("rst_wstrb", bus.mem_wstrb, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_instr", bus.mem_instr, 0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_copy(vecs[i]);

        // Timeout: responder never answers, mem_valid must stay up exactly 8 cycles.
        never_ready = 1;
        src_mem[30'h1400] = 32'hCAFEF00D;
        src_addr = 32'h00005000;
        dst_addr = 32'h00006000;
        word_count = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vcyc = 0; dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.mem_valid) vcyc++;
            if (done) dones++;
            drain();
        end
        chk("timeout_valid_cycles", vcyc, 8);
        chk("timeout_valid_low", bus.mem_valid, 0);
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);
        chk("timeout_no_done", dones, 0);
        chk("timeout_no_write", dst_mem.exists(30'h1800), 0);
        chk("timeout_no_txn", obs_idx, exp_q.size());
        never_ready = 0;
        // A fresh command clears the sticky error (checked right after start).
        run_copy('{32'h00005100, 32'h00006100, 16'd1, 0, 32'h0BADBEEF, 4, 0});

        // Reset in the middle of a stalled write.
        stall_writes = 1;
        lat = 0;
        src_mem[30'h1C00] = 32'h77778888;
        exp_q.push_back('{32'h00007000, 4'h0, 32'h0});
        src_addr = 32'h00007000;
        dst_addr = 32'h00008000;
        word_count = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            drain();
            if (bus.mem_valid && bus.mem_wstrb == 4'hF) got = 1;
        end
        chk("reached_write", got, 1);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("rstw_valid", bus.mem_valid, 0);
        chk("rstw_wstrb", bus.mem_wstrb, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_done", done, 0);
        chk("rstw_addr", bus.mem_addr, 0);
        @(negedge clk);
        chk("rstw_valid_held", bus.mem_valid, 0);
        stall_writes = 0;
        resetn = 1'b1;
        // Start is presented on the very first edge with reset released.
        run_copy('{32'h00007100, 32'h00008100, 16'd1, 0, 32'h13572468, 4, 0});
        chk("rstw_dst_unchanged", dst_mem.exists(30'h2000), 0);

        // Back-to-back: the second start lands in the cycle done pulses.
        va = '{32'h00009000, 32'h0000A000, 16'd2, 0, 32'h42420000, 0, 0};
        vb = '{32'h0000B000, 32'h0000C000, 16'd1, 0, 32'h99990000, 0, 0};
        lat = 0;
        prep(va);
        prep(vb);
        drive_cmd(va);
        @(negedge clk);
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            drain();
            if (done) got = 1;
        end
        chk("b2b_first_done", got, 1);
        drive_cmd(vb);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_accepted", busy, 1);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            drain();
            if (done) got = 1;
        end
        chk("b2b_second_done", got, 1);
        repeat (2) @(negedge clk);
        drain();
        check_dst(va);
        check_dst(vb);
        chk("b2b_all_txns", obs_idx, exp_q.size());

        chk("bus_stable_while_waiting", stable_bad, 0);
        chk("instr_always_low", instr_bad, 0);
        chk("wstrb_low_when_idle", wstrb_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
